// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern and overlap mode.
// Optional saturating hit counter enabled by defining SEQ_MATCH_COUNT_EN.
module seq_detector_param #(
  parameter int unsigned            PATTERN_W       = 4,
  parameter logic [PATTERN_W-1:0]   DEFAULT_PATTERN = PATTERN_W'(4'b1011),
  parameter logic                   DEFAULT_OVERLAP = 1'b1,
  parameter int unsigned            COUNT_W         = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic                 overlap_in,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 match
`ifdef SEQ_MATCH_COUNT_EN
  ,
  output logic [COUNT_W-1:0]   match_count
`endif
);

  localparam int unsigned FILL_W = $clog2(PATTERN_W + 1);

  typedef enum logic {ARMED = 1'b0, HIT = 1'b1} state_t;

  state_t               state;
  logic [PATTERN_W-1:0] hist;
  logic [FILL_W-1:0]    fill;
  logic [PATTERN_W-1:0] pat;
  logic                 ovl;

  logic [PATTERN_W-1:0] nh;
  logic [FILL_W-1:0]    nf;
  logic                 hit;

  // Reject configurations the shift/fill logic cannot represent.
  if (PATTERN_W < 2) begin : g_bad_pattern_w
    $error("PATTERN_W must be at least 2");
  end
  if (COUNT_W < 1) begin : g_bad_count_w
    $error("COUNT_W must be at least 1");
  end

  // Candidate history and fill level if the current bit is accepted.
  always_comb begin
    nh  = {hist[PATTERN_W-2:0], in_bit};
    nf  = (fill == FILL_W'(PATTERN_W)) ? fill : fill + FILL_W'(1);
    hit = (nf == FILL_W'(PATTERN_W)) && (nh == pat);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARMED;
      hist  <= '0;
      fill  <= '0;
      pat   <= DEFAULT_PATTERN;
      ovl   <= DEFAULT_OVERLAP;
    end else if (load) begin
      state <= ARMED;
      hist  <= '0;
      fill  <= '0;
      pat   <= pattern_in;
      ovl   <= overlap_in;
    end else if (in_valid) begin
      hist <= nh;
      if (hit) begin
        state <= HIT;
        // Non-overlap mode forces a full new window before the next hit.
        fill  <= ovl ? FILL_W'(PATTERN_W) : '0;
      end else begin
        state <= ARMED;
        fill  <= nf;
      end
    end else begin
      state <= ARMED;
    end
  end

  assign match = (state == HIT);

`ifdef SEQ_MATCH_COUNT_EN
  // Saturating count of cycles entering or staying in HIT.
  always_ff @(posedge clock) begin
    if (reset || load) begin
      match_count <= '0;
    end else if (in_valid && hit && (match_count != {COUNT_W{1'b1}})) begin
      match_count <= match_count + COUNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table plus random stream against a queue-based model.
module tb_seq_detector_param;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] pattern_in = '0;
  logic         overlap_in = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_bit = 1'b0;
  logic         match;
`ifdef SEQ_MATCH_COUNT_EN
  logic [CW-1:0] match_count;
`endif

  seq_detector_param #(
    .PATTERN_W(W), .DEFAULT_PATTERN(4'b1011), .DEFAULT_OVERLAP(1'b1), .COUNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .load(load), .pattern_in(pattern_in),
    .overlap_in(overlap_in), .in_valid(in_valid), .in_bit(in_bit), .match(match)
`ifdef SEQ_MATCH_COUNT_EN
    , .match_count(match_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         r;
    logic         l;
    logic [W-1:0] p;
    logic         o;
    logic         v;
    logic         b;
    logic         e;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   t5_end = 0;

  // Reference model: the valid bits seen since the last restart point.
  bit           mq[$];
  logic [W-1:0] m_pat = 4'b1011;
  bit           m_ovl = 1'b1;
  bit           m_exp = 1'b0;
  int           m_cnt = 0;

  function automatic void model_step(bit r, bit l, logic [W-1:0] p, bit o, bit v, bit b);
    bit h;
    if (r) begin
      mq.delete(); m_pat = 4'b1011; m_ovl = 1'b1; m_exp = 1'b0; m_cnt = 0;
    end else if (l) begin
      mq.delete(); m_pat = p; m_ovl = o; m_exp = 1'b0; m_cnt = 0;
    end else if (v) begin
      mq.push_back(b);
      if (mq.size() > W) void'(mq.pop_front());
      h = (mq.size() == W);
      for (int i = 0; i < W; i++)
        if (h && (mq[i] != m_pat[W-1-i])) h = 1'b0;
      m_exp = h;
      if (h) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (!m_ovl) mq.delete();
      end
    end else begin
      m_exp = 1'b0;
    end
  endfunction

  function automatic vec_t mk(bit r, bit l, logic [W-1:0] p, bit o, bit v, bit b, bit e);
    vec_t x;
    x.r = r; x.l = l; x.p = p; x.o = o; x.v = v; x.b = b; x.e = e;
    return x;
  endfunction

  task automatic bits(input logic [15:0] seq, input int n, input logic [15:0] exp);
    for (int i = n - 1; i >= 0; i--) tbl.push_back(mk(0, 0, 0, 0, 1, seq[i], exp[i]));
  endtask

  task automatic apply(input bit r, input bit l, input logic [W-1:0] p, input bit o,
                       input bit v, input bit b);
    @(negedge clock);
    reset = r; load = l; pattern_in = p; overlap_in = o; in_valid = v; in_bit = b;
    @(posedge clock);
    model_step(r, l, p, o, v, b);
    #1;
  endtask

  initial begin
    // Test 1: default pattern, single hit then idle.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    bits(16'b1011, 4, 16'b0001);
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    // Test 2: overlap on, then reload with overlap off.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    bits(16'b1011011, 7, 16'b0001001);
    tbl.push_back(mk(0, 1, 4'b1011, 0, 0, 0, 0));
    bits(16'b1011011, 7, 16'b0001000);
    // Test 3: idle gaps between valid bits.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] s;
      s = 4'b1011;
      tbl.push_back(mk(0, 0, 0, 0, 1, s[i], i == 0));
      if (i != 0) begin
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0));
      end
    end
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    // Test 4: load wins over a valid bit, which is dropped.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    bits(16'b101, 3, 16'b000);
    tbl.push_back(mk(0, 1, 4'b0110, 0, 1, 1, 0));
    bits(16'b0110, 4, 16'b0001);
    bits(16'b1011, 4, 16'b0000);
    // Test 5: all-ones pattern with overlap gives back-to-back hits.
    tbl.push_back(mk(0, 1, 4'b1111, 1, 0, 0, 0));
    bits(16'b111111, 6, 16'b000111);
    t5_end = tbl.size() - 1;
    // Test 6: reset during HIT restores the default pattern.
    tbl.push_back(mk(0, 1, 4'b1111, 1, 0, 0, 0));
    bits(16'b1111, 4, 16'b0001);
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    bits(16'b1111, 4, 16'b0000);
    bits(16'b1011, 4, 16'b0001);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].r, tbl[i].l, tbl[i].p, tbl[i].o, tbl[i].v, tbl[i].b);
      n_cmp++;
      if (match !== tbl[i].e) begin
        n_bad++;
        $display("FAIL vec[%0d] match: got %b expected %b", i, match, tbl[i].e);
      end
`ifdef SEQ_MATCH_COUNT_EN
      if (i == t5_end) begin
        n_cmp++;
        if (match_count !== CW'(3)) begin
          n_bad++;
          $display("FAIL count_t5: got %0d expected 3", match_count);
        end
      end
`endif
    end

    // Randomised stream against the model.
    for (int c = 0; c < 3000; c++) begin
      bit r, l, o, v, b;
      logic [W-1:0] p;
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 59) == 0);
      o = $urandom_range(0, 1);
      p = W'($urandom_range(0, 15));
      v = ($urandom_range(0, 9) < 7);
      b = $urandom_range(0, 1);
      apply(r, l, p, o, v, b);
      n_cmp++;
      if (match !== m_exp) begin
        n_bad++;
        $display("FAIL rand[%0d] match: got %b expected %b", c, match, m_exp);
      end
`ifdef SEQ_MATCH_COUNT_EN
      n_cmp++;
      if (match_count !== CW'(m_cnt)) begin
        n_bad++;
        $display("FAIL rand[%0d] count: got %0d expected %0d", c, match_count, m_cnt);
      end
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
